fetch_ctrl: RTL and testbench
=============================

FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 The block SHALL have the ports below; one clock; reset is synchronous and active-high.
REQ-002 clk  in  1  system clock; all state changes on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 pc  in  16  current PC output (address of the instruction being fetched).
REQ-005 rom_req  out  1  fetch request for the ROM word at pc.
REQ-006 rom_ack  in  1  ROM word valid on rom_data this cycle.
REQ-007 rom_data  in  16  instruction word from ROM.
REQ-008 instr  out  16  latched instruction, stable from EXEC entry until the next fetch completes.
REQ-009 instr_valid  out  1  one-cycle strobe when instr is fresh.
REQ-010 exec_done  in  1  CPU execute finished; zr/ng are valid this cycle.
REQ-011 zr, ng  in  1 each  ALU zero and negative flags.
REQ-012 a_reg  in  16  A register, used as the jump target.
REQ-013 pc_in  out  16  PC load value; always equals a_reg.
REQ-014 pc_load, pc_inc, pc_reset  out  1 each  PC controls.
REQ-015 halted  out  1  halt indicator; present only with HALT_DETECT_EN.

Function
REQ-016 The FSM SHALL have the states RST, FETCH, EXEC and UPDATE, plus HALT with the macro.
REQ-017 RST: pc_reset=1 for one cycle, then go to FETCH.
REQ-018 FETCH: rom_req=1; on rom_ack, latch rom_data into instr and go to EXEC. An ack in the first cycle of FETCH (zero-wait ROM) SHALL be accepted.
REQ-019 EXEC: instr_valid=1 only in the first EXEC cycle; hold until exec_done=1, then latch the jump decision and go to UPDATE. exec_done may coincide with instr_valid.
REQ-020 Jump decision: instr[15]=0 (A-instruction) never jumps; otherwise jump = (instr[2]&ng) | (instr[1]&zr) | (instr[0]&~ng&~zr).
REQ-021 UPDATE lasts one cycle: pc_load=jump, pc_inc=~jump, then go to FETCH.
REQ-022 pc_load, pc_inc and pc_reset SHALL be mutually exclusive and zero outside their states.
REQ-023 The block ignores rom_ack outside FETCH and exec_done outside EXEC.
REQ-024 A PC increment from 0xFFFF wraps to 0x0000 (a PC property); the block imposes no limit.
REQ-025 Steady-state loop: FETCH(>=1) + EXEC(>=1) + UPDATE(1) cycles per instruction.

Reset
REQ-026 When reset=1 at a clock edge, the next state SHALL be RST from any state, including mid-FETCH and mid-EXEC.
REQ-027 Values while in RST: rom_req=0, instr=0, instr_valid=0, pc_load=0, pc_inc=0, pc_reset=1, halted=0.
REQ-028 An in-flight rom_ack arriving during reset SHALL be discarded.

Configuration
REQ-029 With HALT_DETECT_EN defined: in UPDATE, a C-instruction with instr[2:0]=3'b111 and a_reg==pc goes to HALT instead of FETCH, with pc_load=0.
REQ-030 HALT behaviour: rom_req=0, all PC controls 0, halted=1; exit is by reset only.
REQ-031 Without HALT_DETECT_EN: the halted port and the HALT state are absent, and a jump-to-self loops normally.

Structure
REQ-032 Shared package hack_pkg holds: the state encoding, the opcode bit index (15), the jump bit positions (2:0) and the width constant (16).
REQ-033 The jump decode SHALL be a combinational sub-module jump_cond (inputs instr, zr, ng; output jump).
REQ-034 The FSM, instr latch and output decode SHALL be in fetch_ctrl.

Verification
REQ-035 Reset, then rom_ack tied high, exec_done tied high, A-instructions only -> pc_reset pulses once, then pc_inc pulses every 3 cycles and pc_load is never 1.
REQ-036 instr=0xE302 (JEQ), zr=1, a_reg=0x0040 -> pc_load=1 and pc_in=0x0040 in UPDATE; with zr=0 the same instruction gives pc_inc=1.
REQ-037 rom_ack delayed 4 cycles -> rom_req held 4 cycles, instr_valid pulses exactly once, and instr=rom_data of the ack cycle.
REQ-038 Reset asserted during FETCH with a late ack -> RST next cycle and the ack is ignored; reset asserted during EXEC -> no pc_load or pc_inc is issued.
REQ-039 HALT_DETECT_EN: instr=0xEA87 (0;JMP), a_reg==pc=0x0012 -> halted=1, rom_req stays 0 for 20 cycles, and reset clears halted.
REQ-040 Random instructions, flags and ack delays for 1000 instructions -> a reference model of pc (load a_reg / inc / reset) matches every UPDATE.

Source files
------------

// File: rtl/hack_pkg.sv
// Shared encodings for the Hack fetch controller: word width, opcode/jump bit positions, FSM states.
// The HALT state only exists when HALT_DETECT_EN is defined.
package hack_pkg;

  localparam int WORD_W     = 16;
  localparam int OPCODE_BIT = 15;
  localparam int JMP_HI     = 2;
  localparam int JMP_LO     = 0;
  localparam int JMP_LT_BIT = 2;
  localparam int JMP_EQ_BIT = 1;
  localparam int JMP_GT_BIT = 0;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [2:0] {
    ST_RST    = 3'd0,
    ST_FETCH  = 3'd1,
    ST_EXEC   = 3'd2,
    ST_UPDATE = 3'd3
`ifdef HALT_DETECT_EN
    ,
    ST_HALT   = 3'd4
`endif
  } state_t;

  function automatic logic is_c_instr(input word_t w);
    return w[OPCODE_BIT];
  endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// Bundle between the fetch controller (master) and the ROM/CPU/PC environment (slave).
// The halted indicator is only present when HALT_DETECT_EN is defined.
interface fetch_ctrl_if import hack_pkg::*; ();

  word_t pc;
  logic  rom_req;
  logic  rom_ack;
  word_t rom_data;
  word_t instr;
  logic  instr_valid;
  logic  exec_done;
  logic  zr;
  logic  ng;
  word_t a_reg;
  word_t pc_in;
  logic  pc_load;
  logic  pc_inc;
  logic  pc_reset;
`ifdef HALT_DETECT_EN
  logic  halted;
`endif

  modport master (
    input  pc, rom_ack, rom_data, exec_done, zr, ng, a_reg,
    output rom_req, instr, instr_valid, pc_in, pc_load, pc_inc, pc_reset
`ifdef HALT_DETECT_EN
    , output halted
`endif
  );

  modport slave (
    output pc, rom_ack, rom_data, exec_done, zr, ng, a_reg,
    input  rom_req, instr, instr_valid, pc_in, pc_load, pc_inc, pc_reset
`ifdef HALT_DETECT_EN
    , input halted
`endif
  );

endinterface

// File: rtl/fetch_ctrl_jump_cond.sv
// Combinational Hack jump decode: A-instructions never jump, C-instructions test the j-bits against zr/ng.
// Zero latency; no handshake.
module jump_cond import hack_pkg::*; (
  input  word_t instr,
  input  logic  zr,
  input  logic  ng,
  output logic  jump
);

  logic unused_bits;
  assign unused_bits = ^instr[OPCODE_BIT-1:JMP_HI+1];

  always_comb begin
    jump = 1'b0;
    if (is_c_instr(instr)) begin
      jump = (instr[JMP_LT_BIT] & ng)
           | (instr[JMP_EQ_BIT] & zr)
           | (instr[JMP_GT_BIT] & ~ng & ~zr);
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Hack CPU fetch controller: RST -> FETCH (waits on rom_ack) -> EXEC (waits on exec_done) -> UPDATE (1 cycle).
// Optional HALT state on a jump-to-self, enabled by HALT_DETECT_EN; exit only via reset.
module fetch_ctrl import hack_pkg::*; (
  input  logic         clk,
  input  logic         reset,
  fetch_ctrl_if.master bus
);

  state_t state_q, state_d;
  word_t  instr_q, instr_d;
  logic   first_q, first_d;
  logic   jump_q,  jump_d;
  logic   jump_w;

  jump_cond u_jump_cond (
    .instr (instr_q),
    .zr    (bus.zr),
    .ng    (bus.ng),
    .jump  (jump_w)
  );

`ifdef HALT_DETECT_EN
  logic self_loop;
  assign self_loop = is_c_instr(instr_q)
                   && (instr_q[JMP_HI:JMP_LO] == 3'b111)
                   && (bus.a_reg == bus.pc);
`else
  logic unused_pc;
  assign unused_pc = ^bus.pc;
`endif

  assign bus.pc_in       = bus.a_reg;
  assign bus.instr       = instr_q;
  assign bus.instr_valid = first_q && (state_q == ST_EXEC);

  always_comb begin
    state_d      = state_q;
    instr_d      = instr_q;
    first_d      = 1'b0;
    jump_d       = jump_q;
    bus.rom_req  = 1'b0;
    bus.pc_load  = 1'b0;
    bus.pc_inc   = 1'b0;
    bus.pc_reset = 1'b0;
`ifdef HALT_DETECT_EN
    bus.halted   = 1'b0;
`endif
    unique case (state_q)
      ST_RST: begin
        bus.pc_reset = 1'b1;
        state_d      = ST_FETCH;
      end
      ST_FETCH: begin
        bus.rom_req = 1'b1;
        if (bus.rom_ack) begin
          instr_d = bus.rom_data;
          first_d = 1'b1;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        // flags are only meaningful in the exec_done cycle, so the decision is captured here
        if (bus.exec_done) begin
          jump_d  = jump_w;
          state_d = ST_UPDATE;
        end
      end
      ST_UPDATE: begin
        state_d = ST_FETCH;
`ifdef HALT_DETECT_EN
        if (self_loop) begin
          state_d = ST_HALT;
        end else begin
          bus.pc_load = jump_q;
          bus.pc_inc  = ~jump_q;
        end
`else
        bus.pc_load = jump_q;
        bus.pc_inc  = ~jump_q;
`endif
      end
`ifdef HALT_DETECT_EN
      ST_HALT: begin
        bus.halted = 1'b1;
      end
`endif
      default: begin
        instr_d = '0;
        state_d = ST_RST;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_RST;
      instr_q <= '0;
      first_q <= 1'b0;
      jump_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      first_q <= first_d;
      jump_q  <= jump_d;
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios plus 1000 random instructions against a PC reference model.
// Define HALT_DETECT_EN to exercise the halt path.
module tb_fetch_ctrl;
  import hack_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fetch_ctrl_if bus ();

  fetch_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  int    n_run  = 0;
  int    n_fail = 0;
  word_t pc_nxt;
  word_t model_pc;
  word_t last_instr;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Hack jump table on the raw flags (flags may be inconsistent in random stimulus).
  function automatic logic ref_jump(input word_t w, input logic z, input logic n);
    logic [2:0] jb;
    if (!w[15]) return 1'b0;
    jb = w[2:0];
    case (jb)
      3'd0:    return 1'b0;
      3'd1:    return !z && !n;
      3'd2:    return z;
      3'd3:    return z || !n;
      3'd4:    return n;
      3'd5:    return n || !z;
      3'd6:    return z || n;
      default: return 1'b1;
    endcase
  endfunction

  // The external PC register reacts to the controls seen in the current cycle.
  task automatic settle();
    #1;
    if (bus.pc_reset)     pc_nxt = '0;
    else if (bus.pc_load) pc_nxt = bus.pc_in;
    else if (bus.pc_inc)  pc_nxt = bus.pc + 16'd1;
    else                  pc_nxt = bus.pc;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    bus.pc = pc_nxt;
  endtask

  task automatic drive(input logic ack, input word_t dat, input logic done,
                       input logic z, input logic n, input word_t a);
    bus.rom_ack   = ack;
    bus.rom_data  = dat;
    bus.exec_done = done;
    bus.zr        = z;
    bus.ng        = n;
    bus.a_reg     = a;
  endtask

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic chk_rst(input string tag);
    chk({tag, "_req"},   bus.rom_req, 1'b0);
    chk({tag, "_instr"}, bus.instr, 16'h0000);
    chk({tag, "_vld"},   bus.instr_valid, 1'b0);
    chk({tag, "_ctl"},   {bus.pc_load, bus.pc_inc, bus.pc_reset}, 3'b001);
`ifdef HALT_DETECT_EN
    chk({tag, "_halt"},  bus.halted, 1'b0);
`endif
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(1'b1, 16'hBEEF, 1'b1, 1'b0, 1'b0, 16'h0000);
    tick();
    tick();
    settle();
    chk_rst("rst_held");
    reset = 1'b0;
    settle();
    chk_rst("rst_last");
    tick();
    model_pc   = '0;
    last_instr = '0;
    chk("rst_pc", bus.pc, 16'h0000);
  endtask

  // Starts in the first FETCH cycle, ends in the next FETCH cycle.
  task automatic run_instr(input int d, input word_t w, input int e,
                           input logic z, input logic n, input word_t a);
    logic j;
    for (int i = 0; i <= d; i++) begin
      drive(i == d, (i == d) ? w : ~w, rbit(), rbit(), rbit(), a);
      settle();
      chk("fetch_req", bus.rom_req, 1'b1);
      chk("fetch_vld", bus.instr_valid, 1'b0);
      chk("fetch_hold", bus.instr, last_instr);
      chk("fetch_ctl", {bus.pc_load, bus.pc_inc, bus.pc_reset}, 3'b000);
      tick();
    end
    last_instr = w;
    for (int k = 0; k <= e; k++) begin
      drive(rbit(), word_t'($urandom), k == e, (k == e) ? z : rbit(), (k == e) ? n : rbit(), a);
      settle();
      chk("exec_req", bus.rom_req, 1'b0);
      chk("exec_vld", bus.instr_valid, k == 0);
      chk("exec_instr", bus.instr, w);
      chk("exec_ctl", {bus.pc_load, bus.pc_inc, bus.pc_reset}, 3'b000);
      tick();
    end
    drive(rbit(), word_t'($urandom), rbit(), rbit(), rbit(), a);
    settle();
    j = ref_jump(w, z, n);
    chk("upd_load", bus.pc_load, j);
    chk("upd_inc", bus.pc_inc, !j);
    chk("upd_rst", bus.pc_reset, 1'b0);
    chk("upd_pcin", bus.pc_in, a);
    chk("upd_req", bus.rom_req, 1'b0);
    model_pc = j ? a : model_pc + 16'd1;
    tick();
    chk("pc_model", bus.pc, model_pc);
  endtask

  initial begin
    word_t w;
    word_t a;
    bus.pc = 16'h1234;
    pc_nxt = 16'h1234;
    reset  = 1'b1;
    drive(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000);

    do_reset();

    // Zero-wait ROM, immediate exec_done, A-instructions only: 3-cycle loop, always increment.
    for (int i = 0; i < 6; i++)
      run_instr(0, {1'b0, 15'($urandom)}, 0, rbit(), rbit(), word_t'($urandom));
    chk("a_only_pc", bus.pc, 16'h0006);

    // JEQ taken / not taken.
    run_instr(0, 16'hE302, 0, 1'b1, 1'b0, 16'h0040);
    chk("jeq_taken_pc", bus.pc, 16'h0040);
    run_instr(0, 16'hE302, 0, 1'b0, 1'b0, 16'h0040);
    chk("jeq_fall_pc", bus.pc, 16'h0041);

    // Slow ROM, multi-cycle exec.
    run_instr(4, 16'hEC10, 2, 1'b0, 1'b1, 16'h0100);

    // Reset in FETCH while an ack arrives, and an ack during the RST cycle.
    drive(1'b0, 16'h1111, 1'b1, 1'b0, 1'b0, 16'h0000);
    settle();
    tick();
    reset = 1'b1;
    drive(1'b1, 16'hBEEF, 1'b1, 1'b0, 1'b0, 16'h0000);
    settle();
    tick();
    reset = 1'b0;
    drive(1'b1, 16'hCAFE, 1'b1, 1'b0, 1'b0, 16'h0000);
    settle();
    chk_rst("rstf");
    tick();
    drive(1'b0, 16'h2222, 1'b0, 1'b0, 1'b0, 16'h0000);
    settle();
    chk("rstf_req", bus.rom_req, 1'b1);
    chk("rstf_instr", bus.instr, 16'h0000);
    chk("rstf_pc", bus.pc, 16'h0000);
    tick();
    model_pc   = '0;
    last_instr = '0;
    run_instr(1, 16'h0005, 0, 1'b0, 1'b0, 16'h0000);

    // Reset in EXEC: the pending JMP must not reach UPDATE.
    drive(1'b1, 16'hEA87, 1'b0, 1'b0, 1'b0, 16'h0077);
    settle();
    tick();
    drive(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0077);
    settle();
    chk("rste_vld", bus.instr_valid, 1'b1);
    tick();
    reset = 1'b1;
    drive(1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0077);
    settle();
    tick();
    reset = 1'b0;
    settle();
    chk_rst("rste");
    tick();
    model_pc   = '0;
    last_instr = '0;
    chk("rste_pc", bus.pc, 16'h0000);

`ifdef HALT_DETECT_EN
    // Jump to 0x0012, then a jump-to-self there halts the controller.
    run_instr(0, 16'hEA87, 0, 1'b0, 1'b0, 16'h0012);
    chk("halt_pc", bus.pc, 16'h0012);
    drive(1'b1, 16'hEA87, 1'b0, 1'b0, 1'b0, 16'h0012);
    settle();
    tick();
    drive(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0012);
    settle();
    tick();
    drive(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0012);
    settle();
    chk("halt_upd_ctl", {bus.pc_load, bus.pc_inc, bus.pc_reset}, 3'b000);
    tick();
    for (int i = 0; i < 20; i++) begin
      drive(rbit(), word_t'($urandom), rbit(), rbit(), rbit(), 16'h0012);
      settle();
      chk("halt_req", bus.rom_req, 1'b0);
      chk("halt_flag", bus.halted, 1'b1);
      chk("halt_ctl", {bus.pc_load, bus.pc_inc, bus.pc_reset}, 3'b000);
      tick();
    end
    do_reset();
`else
    // Without halt detection a jump-to-self simply loops.
    run_instr(0, 16'hEA87, 0, 1'b0, 1'b0, 16'h0000);
    run_instr(0, 16'hEA87, 0, 1'b0, 1'b0, 16'h0000);
    chk("self_loop_pc", bus.pc, 16'h0000);
`endif

    // Random instructions, flags and latencies.
    for (int i = 0; i < 1000; i++) begin
      w = word_t'($urandom);
      a = word_t'($urandom);
      if (i % 97 == 0) begin
        a = 16'hFFFF;
        w = 16'hEA87;
      end
`ifdef HALT_DETECT_EN
      if (w[15] && (w[2:0] == 3'b111) && (a == model_pc)) a = a ^ 16'h0001;
`endif
      run_instr(int'($urandom_range(0, 4)), w, int'($urandom_range(0, 3)), rbit(), rbit(), a);
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
